// File: rtl/janela_conv_if.sv
// Handshake and data bundle between a pixel source / window consumer and janela_conv.
interface janela_conv_if;
  logic         start;
  logic [7:0]   pix_in;
  logic         pix_valid;
  logic         pix_ready;
  logic [199:0] win_out;
  logic         win_valid;
  logic         win_ack;
  logic         busy;
  logic         frame_done;

  modport master (
    output start, pix_in, pix_valid, win_ack,
    input  pix_ready, win_out, win_valid, busy, frame_done
  );

  modport slave (
    input  start, pix_in, pix_valid, win_ack,
    output pix_ready, win_out, win_valid, busy, frame_done
  );
endinterface

// File: rtl/janela_conv.sv
// 5x5 sliding-window generator: raster pixels in, one registered window per
// valid position out, with a hold state that stalls input until the window is acked.
module janela_conv #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 6
) (
  input  logic         clk,
  input  logic         reset,
  janela_conv_if.slave bus
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          last_q, last_d;
  logic          pix_ready_q, pix_ready_d;
  logic          win_valid_q, win_valid_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    lb_q  [4][IMG_W];
  logic [7:0]    lb_d  [4][IMG_W];
  logic [7:0]    win_q [5][5];
  logic [7:0]    win_d [5][5];

  // Next-state, counters, line buffers and window shift; outputs are derived from the next state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    last_d  = last_q;
    lb_d    = lb_q;
    win_d   = win_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
          last_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.pix_valid) begin
          for (int unsigned r = 0; r < 5; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
              win_d[r][c] = win_q[r][c+1];
            end
          end
          // New right column reads the buffers before this pixel's update lands.
          win_d[0][4] = lb_q[3][col_q];
          win_d[1][4] = lb_q[2][col_q];
          win_d[2][4] = lb_q[1][col_q];
          win_d[3][4] = lb_q[0][col_q];
          win_d[4][4] = bus.pix_in;
          lb_d[3][col_q] = lb_q[2][col_q];
          lb_d[2][col_q] = lb_q[1][col_q];
          lb_d[1][col_q] = lb_q[0][col_q];
          lb_d[0][col_q] = bus.pix_in;
          if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (row_q >= RW'(4) && col_q >= CW'(4)) begin
            state_d = HOLD;
            last_d  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
          end
        end
      end
      HOLD: begin
        if (bus.win_ack) begin
          state_d = last_q ? DONE : RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pix_ready_d  = (state_d == RUN);
    win_valid_d  = (state_d == HOLD);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  // Control state, counters, window register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      last_q       <= 1'b0;
      pix_ready_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      win_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      last_q       <= last_d;
      pix_ready_q  <= pix_ready_d;
      win_valid_q  <= win_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffers carry no reset; stale contents only reach window columns that are never presented.
  always_ff @(posedge clk) begin
    lb_q <= lb_d;
  end

  // Flatten the window: row 0 (oldest) / column 0 (left) in the low byte.
  always_comb begin
    bus.win_out = '0;
    for (int unsigned r = 0; r < 5; r++) begin
      for (int unsigned c = 0; c < 5; c++) begin
        bus.win_out[(r*5+c)*8 +: 8] = win_q[r][c];
      end
    end
  end

  assign bus.pix_ready  = pix_ready_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_janela_conv.sv
// Scoreboard bench for janela_conv at 8x6: expected windows are pushed when a
// valid-position pixel is handed over and popped when the DUT presents a window.
module tb_janela_conv;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  typedef struct {
    logic [199:0] win;
    int           pos;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] img [6][8];

  janela_conv_if bus ();

  janela_conv #(.IMG_W(8), .IMG_H(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [199:0] mk_win(input int row, input int col);
    logic [199:0] w;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w[(r*5+c)*8 +: 8] = img[row-4+r][col-4+c];
      end
    end
    return w;
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, bus.pix_ready, 0);
    chk({tag, "_wvalid"}, bus.win_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_fdone"}, bus.frame_done, 0);
    chk({tag, "_wout"}, bus.win_out, 0);
  endtask

  task automatic run_frame(input bit rnd_valid, input bit rnd_data, input int bp_win);
    int idx = 0;
    int wins = 0;
    int fd = 0;
    int cyc = 0;
    int hold_cnt = 0;
    bit in_win = 0;
    bit fd_prev = 0;
    bit done = 0;
    bit v;
    logic [199:0] held = '0;
    exp_t e;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = rnd_data ? 8'($urandom_range(0, 255)) : 8'(r*8 + c);
    sb.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.pix_valid = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!done && cyc < 3000) begin
      cyc++;
      if (fd_prev) begin
        chk("done_pulse", bus.frame_done, 0);
        chk("busy_after_done", bus.busy, 0);
        done = 1;
      end else if (bus.frame_done) begin
        fd++;
        fd_prev = 1;
        chk("busy_in_done", bus.busy, 1);
      end
      if (bus.win_valid) begin
        chk("ready_in_hold", bus.pix_ready, 0);
        if (!in_win) begin
          in_win = 1;
          hold_cnt = 0;
          wins++;
          held = bus.win_out;
          if (sb.size() == 0) begin
            chk("win_unexpected", bus.win_valid, 0);
          end else begin
            e = sb.pop_front();
            chk("win_data", bus.win_out, e.win);
            chk("win_latency", idx, e.pos + 1);
          end
          if (!rnd_data && wins == 1) begin
            chk("first_e0", bus.win_out[7:0], 0);
            chk("first_e12", bus.win_out[103:96], 18);
            chk("first_e24", bus.win_out[199:192], 36);
          end
        end else begin
          chk("win_stable", bus.win_out, held);
        end
        bus.win_ack = !(wins == bp_win && hold_cnt < 10);
        hold_cnt++;
        // start and pix_valid during HOLD must be ignored
        bus.start = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in = 8'($urandom);
      end else begin
        in_win = 0;
        bus.win_ack = 1'b1;
        bus.start = 1'b0;
        if (idx < 48) begin
          v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
          bus.pix_valid = v;
          bus.pix_in = v ? img[idx/8][idx%8] : 8'($urandom);
          if (v && bus.pix_ready) begin
            if (idx/8 >= 4 && idx%8 >= 4) begin
              e.win = mk_win(idx/8, idx%8);
              e.pos = idx;
              sb.push_back(e);
            end
            idx++;
          end
        end else begin
          bus.pix_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    chk("frame_timeout", done, 1);
    chk("win_count", wins, 8);
    chk("done_count", fd, 1);
    chk("pix_count", idx, 48);
    chk("sb_empty", sb.size(), 0);
    if (!rnd_data) begin
      chk("last_e0", held[7:0], 11);
      chk("last_e24", held[199:192], 47);
    end
  endtask

  task automatic abort_frame(input int n_pix);
    int idx = 0;
    int cyc = 0;
    int fd = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (idx < n_pix && cyc < 500) begin
      cyc++;
      bus.pix_valid = 1'b1;
      bus.pix_in = 8'(idx);
      if (bus.pix_ready) idx++;
      @(negedge clk);
    end
    chk("abort_reached", idx, n_pix);
    bus.pix_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("abort_rst");
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.frame_done) fd++;
    end
    chk("abort_no_done", fd, 0);
    chk("abort_idle_busy", bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.pix_in = '0;
    bus.pix_valid = 1'b0;
    bus.win_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b0;
    // pix_valid and win_ack in IDLE are ignored
    bus.pix_valid = 1'b1;
    bus.win_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", bus.pix_ready, 0);
    chk("idle_busy", bus.busy, 0);
    bus.pix_valid = 1'b0;

    run_frame(1'b0, 1'b0, 0);   // continuous stream, ack always high
    run_frame(1'b0, 1'b0, 2);   // backpressure on second window
    run_frame(1'b1, 1'b0, 0);   // random pix_valid
    abort_frame(20);
    run_frame(1'b0, 1'b0, 0);   // fresh frame after abort
    run_frame(1'b1, 1'b1, 5);   // random data, random valid, backpressure

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
